// File: rtl/dht_uart_reporter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dht_uart_reporter_pkg
//  Brief    : ASCII constants, line lengths and FSM encoding shared by the
//             DHT11 report sequencer and its helpers.
//  Revision : 1.0  initial release
// ============================================================================
package dht_uart_reporter_pkg;

   localparam logic [7:0] CHR_H     = 8'h48;
   localparam logic [7:0] CHR_T     = 8'h54;
   localparam logic [7:0] CHR_EQ    = 8'h3D;
   localparam logic [7:0] CHR_COMMA = 8'h2C;
   localparam logic [7:0] CHR_CR    = 8'h0D;
   localparam logic [7:0] CHR_LF    = 8'h0A;
   localparam logic [7:0] CHR_0     = 8'h30;

   localparam int MSG_LEN_CRLF   = 13;
   localparam int MSG_LEN_NOCRLF = 11;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_CONV_H    = 3'd1,
      ST_CONV_T    = 3'd2,
      ST_LOAD      = 3'd3,
      ST_SEND      = 3'd4,
      ST_WAIT_ACK  = 3'd5,
      ST_WAIT_DONE = 3'd6,
      ST_FINISH    = 3'd7
   } state_t;

   // One BCD digit rendered as its ASCII character.
   function automatic logic [7:0] ascii_digit(input logic [3:0] d);
      return CHR_0 + {4'h0, d};
   endfunction

endpackage
`default_nettype wire

// File: rtl/dht_uart_reporter_bin2bcd8.sv
`default_nettype none
// ============================================================================
//  Module   : bin2bcd8
//  Brief    : Serial 8-bit double-dabble converter. A start pulse loads the
//             operand; eight shift cycles later done pulses for one cycle
//             and bcd holds the three-digit result.
//  Revision : 1.0  initial release
// ============================================================================
module bin2bcd8 (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [7:0]  bin,
   output logic [11:0] bcd,
   output logic        done
);

   logic [7:0]  r_bin;
   logic [11:0] r_bcd;
   logic [3:0]  r_cnt;
   logic        r_done;
   logic [10:0] w_adj;

   // Add-3 correction on units and tens before each shift; the hundreds
   // digit of an 8-bit operand never reaches 5, so it is passed through.
   always_comb begin
      w_adj = r_bcd[10:0];
      if (r_bcd[3:0] >= 4'd5) w_adj[3:0] = r_bcd[3:0] + 4'd3;
      if (r_bcd[7:4] >= 4'd5) w_adj[7:4] = r_bcd[7:4] + 4'd3;
   end

   // Load on start, then shift one binary bit into the BCD field per cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_bin  <= 8'h00;
         r_bcd  <= 12'h000;
         r_cnt  <= 4'd0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (start) begin
            r_bin <= bin;
            r_bcd <= 12'h000;
            r_cnt <= 4'd8;
         end else if (r_cnt != 4'd0) begin
            {r_bcd, r_bin} <= {w_adj, r_bin, 1'b0};
            r_cnt          <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) r_done <= 1'b1;
         end
      end
   end

   assign bcd  = r_bcd;
   assign done = r_done;

endmodule
`default_nettype wire

// File: rtl/dht_uart_reporter.sv
`default_nettype none
// ============================================================================
//  Module   : dht_uart_reporter
//  Brief    : Turns one DHT11 sample into "H=hhh,T=ttt[CR LF]" and streams it
//             byte by byte into uart_tx over the send/busy handshake.
//  Revision : 1.0  initial release
// ============================================================================
module dht_uart_reporter
   import dht_uart_reporter_pkg::*;
#(
   parameter int ADD_CRLF    = 1,
   parameter int ACK_TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] humid,
   input  logic [7:0] temp,
   input  logic       sample_valid,
   input  logic       tx_busy,
   output logic [7:0] tx_data,
   output logic       tx_send,
   output logic       report_busy,
   output logic       report_done,
   output logic       dropped,
   output logic       tx_err
);

   localparam logic [3:0] c_LAST_IDX = (ADD_CRLF != 0) ? 4'(MSG_LEN_CRLF - 1)
                                                       : 4'(MSG_LEN_NOCRLF - 1);
   localparam logic [7:0] c_ACK_LAST = 8'(ACK_TIMEOUT - 1);

   state_t      r_state, w_state_next;
   logic [7:0]  r_humid, r_temp;
   logic [11:0] r_bcd_h, r_bcd_t;
   logic [3:0]  r_idx;
   logic [7:0]  r_ack_cnt;
   logic        r_kick;
   logic [7:0]  r_tx_data;
   logic        r_report_busy, r_report_done, r_dropped, r_tx_err;
   logic        w_tx_send;
   logic [7:0]  w_bin;
   logic [11:0] w_bcd;
   logic        w_conv_done;
   logic [7:0]  w_char;

   // The single converter serves humidity first, then temperature.
   assign w_bin = (r_state == ST_CONV_H) ? r_humid : r_temp;

   bin2bcd8 u_bcd (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (r_kick),
      .bin     (w_bin),
      .bcd     (w_bcd),
      .done    (w_conv_done)
   );

   // Character at the current byte index of the report line.
   always_comb begin
      w_char = 8'h00;
      case (r_idx)
         4'd0:    w_char = CHR_H;
         4'd1:    w_char = CHR_EQ;
         4'd2:    w_char = ascii_digit(r_bcd_h[11:8]);
         4'd3:    w_char = ascii_digit(r_bcd_h[7:4]);
         4'd4:    w_char = ascii_digit(r_bcd_h[3:0]);
         4'd5:    w_char = CHR_COMMA;
         4'd6:    w_char = CHR_T;
         4'd7:    w_char = CHR_EQ;
         4'd8:    w_char = ascii_digit(r_bcd_t[11:8]);
         4'd9:    w_char = ascii_digit(r_bcd_t[7:4]);
         4'd10:   w_char = ascii_digit(r_bcd_t[3:0]);
         4'd11:   w_char = CHR_CR;
         4'd12:   w_char = CHR_LF;
         default: w_char = 8'h00;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= ST_IDLE;
      else          r_state <= w_state_next;
   end

   // Next-state decode; tx_send is gated by busy so it can never overlap it.
   always_comb begin
      w_state_next = r_state;
      w_tx_send    = 1'b0;
      case (r_state)
         ST_IDLE:      if (sample_valid) w_state_next = ST_CONV_H;
         ST_CONV_H:    if (w_conv_done)  w_state_next = ST_CONV_T;
         ST_CONV_T:    if (w_conv_done)  w_state_next = ST_LOAD;
         ST_LOAD:      w_state_next = ST_SEND;
         ST_SEND: begin
            if (!tx_busy) begin
               w_tx_send    = 1'b1;
               w_state_next = ST_WAIT_ACK;
            end
         end
         ST_WAIT_ACK: begin
            if (tx_busy)                      w_state_next = ST_WAIT_DONE;
            else if (r_ack_cnt == c_ACK_LAST) w_state_next = ST_IDLE;
         end
         ST_WAIT_DONE: begin
            if (!tx_busy) w_state_next = (r_idx == c_LAST_IDX) ? ST_FINISH : ST_LOAD;
         end
         ST_FINISH:    w_state_next = ST_IDLE;
         default:      w_state_next = ST_IDLE;
      endcase
   end

   // Datapath: sample capture, BCD storage, byte index, ack timer, status pulses.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_humid       <= 8'h00;
         r_temp        <= 8'h00;
         r_bcd_h       <= 12'h000;
         r_bcd_t       <= 12'h000;
         r_idx         <= 4'd0;
         r_ack_cnt     <= 8'd0;
         r_kick        <= 1'b0;
         r_tx_data     <= 8'h00;
         r_report_busy <= 1'b0;
         r_report_done <= 1'b0;
         r_dropped     <= 1'b0;
         r_tx_err      <= 1'b0;
      end else begin
         r_kick        <= 1'b0;
         r_report_done <= 1'b0;
         r_tx_err      <= 1'b0;
         r_dropped     <= sample_valid && (r_state != ST_IDLE);
         case (r_state)
            ST_IDLE: begin
               if (sample_valid) begin
                  r_humid       <= humid;
                  r_temp        <= temp;
                  r_idx         <= 4'd0;
                  r_report_busy <= 1'b1;
                  r_kick        <= 1'b1;
               end
            end
            ST_CONV_H: begin
               if (w_conv_done) begin
                  r_bcd_h <= w_bcd;
                  r_kick  <= 1'b1;
               end
            end
            ST_CONV_T: if (w_conv_done) r_bcd_t <= w_bcd;
            ST_LOAD: begin
               r_tx_data <= w_char;
               r_ack_cnt <= 8'd0;
            end
            ST_WAIT_ACK: begin
               if (!tx_busy) begin
                  if (r_ack_cnt == c_ACK_LAST) begin
                     r_tx_err      <= 1'b1;
                     r_report_busy <= 1'b0;
                  end else begin
                     r_ack_cnt <= r_ack_cnt + 8'd1;
                  end
               end
            end
            ST_WAIT_DONE: begin
               if (!tx_busy && (r_idx != c_LAST_IDX)) r_idx <= r_idx + 4'd1;
            end
            ST_FINISH: begin
               r_report_done <= 1'b1;
               r_report_busy <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign tx_data     = r_tx_data;
   assign tx_send     = w_tx_send;
   assign report_busy = r_report_busy;
   assign report_done = r_report_done;
   assign dropped     = r_dropped;
   assign tx_err      = r_tx_err;

endmodule
`default_nettype wire

// File: tb/tb_dht_uart_reporter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dht_uart_reporter
//  Brief    : Self-checking bench: two reporters (with and without CR LF),
//             each driving a small uart_tx busy model; a byte scoreboard
//             per instance checks every transmitted character.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dht_uart_reporter;

   localparam int BUSY_A = 104;
   localparam int BUSY_B = 20;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] humid = 8'h00, temp = 8'h00;
   logic       sv_a = 1'b0, sv_b = 1'b0;
   logic       stuck_a = 1'b0, force_busy_a = 1'b0;

   logic [7:0] tx_data_a, tx_data_b;
   logic       tx_send_a, tx_send_b, tx_busy_a, tx_busy_b;
   logic       rbusy_a, rbusy_b, rdone_a, rdone_b, drop_a, drop_b, err_a, err_b;

   int cnt_a = 0, cnt_b = 0;
   int sends_a = 0, sends_b = 0, dones_a = 0, dones_b = 0;
   int drops_a = 0, errs_a = 0, errs_b = 0;
   logic [7:0] held_a = 8'h00;
   logic       in_byte_a = 1'b0;
   logic [7:0] q_a[$];
   logic [7:0] q_b[$];

   int n_pass = 0, n_total = 0, n_fail = 0;

   always #5 clk = ~clk;

   dht_uart_reporter #(.ADD_CRLF(1), .ACK_TIMEOUT(15)) dut_a (
      .clk(clk), .reset_n(reset_n), .humid(humid), .temp(temp),
      .sample_valid(sv_a), .tx_busy(tx_busy_a), .tx_data(tx_data_a),
      .tx_send(tx_send_a), .report_busy(rbusy_a), .report_done(rdone_a),
      .dropped(drop_a), .tx_err(err_a));

   dht_uart_reporter #(.ADD_CRLF(0), .ACK_TIMEOUT(15)) dut_b (
      .clk(clk), .reset_n(reset_n), .humid(humid), .temp(temp),
      .sample_valid(sv_b), .tx_busy(tx_busy_b), .tx_data(tx_data_b),
      .tx_send(tx_send_b), .report_busy(rbusy_b), .report_done(rdone_b),
      .dropped(drop_b), .tx_err(err_b));

   // uart_tx models: busy for a fixed number of cycles after each send.
   assign tx_busy_a = force_busy_a || (cnt_a != 0);
   assign tx_busy_b = (cnt_b != 0);

   always @(posedge clk) begin
      if (cnt_a != 0)                   cnt_a <= cnt_a - 1;
      else if (tx_send_a && !stuck_a)   cnt_a <= BUSY_A;
      if (cnt_b != 0)                   cnt_b <= cnt_b - 1;
      else if (tx_send_b)               cnt_b <= BUSY_B;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] line_byte(input int k, input int h, input int t);
      case (k)
         0: return 8'h48;
         1: return 8'h3D;
         2: return 8'(48 + h / 100);
         3: return 8'(48 + (h / 10) % 10);
         4: return 8'(48 + h % 10);
         5: return 8'h2C;
         6: return 8'h54;
         7: return 8'h3D;
         8: return 8'(48 + t / 100);
         9: return 8'(48 + (t / 10) % 10);
         10: return 8'(48 + t % 10);
         11: return 8'h0D;
         default: return 8'h0A;
      endcase
   endfunction

   // Scoreboard pop and protocol checks on the falling edge.
   always @(negedge clk) begin
      if (!reset_n) begin
         in_byte_a <= 1'b0;
      end else begin
         if (tx_send_a) begin
            sends_a <= sends_a + 1;
            check("a_send_while_busy", {31'd0, tx_busy_a}, 0);
            if (q_a.size() == 0) check("a_unexpected_send", {24'd0, tx_data_a}, 32'hFFFF);
            else                 check("a_byte", {24'd0, tx_data_a}, {24'd0, q_a.pop_front()});
            held_a    <= tx_data_a;
            in_byte_a <= 1'b1;
         end else if (in_byte_a && (err_a || (!tx_busy_a && cnt_a == 0 && !force_busy_a && dut_a.r_state == 3'd3))) begin
            in_byte_a <= 1'b0;
         end
         if (in_byte_a && tx_busy_a && cnt_a == 1) begin
            check("a_data_stable", {24'd0, tx_data_a}, {24'd0, held_a});
            in_byte_a <= 1'b0;
         end
         if (tx_send_b) begin
            sends_b <= sends_b + 1;
            if (q_b.size() == 0) check("b_unexpected_send", {24'd0, tx_data_b}, 32'hFFFF);
            else                 check("b_byte", {24'd0, tx_data_b}, {24'd0, q_b.pop_front()});
         end
         if (rdone_a) dones_a <= dones_a + 1;
         if (rdone_b) dones_b <= dones_b + 1;
         if (drop_a)  drops_a <= drops_a + 1;
         if (err_a)   errs_a  <= errs_a + 1;
         if (err_b)   errs_b  <= errs_b + 1;
      end
   end

   task automatic pulse_a(input int h, input int t);
      humid = 8'(h); temp = 8'(t); sv_a = 1'b1;
      @(negedge clk);
      sv_a = 1'b0;
   endtask

   task automatic push_a(input int h, input int t);
      for (int k = 0; k < 13; k++) q_a.push_back(line_byte(k, h, t));
   endtask

   task automatic wait_done_a(input string tag);
      int d0 = dones_a;
      for (int i = 0; i < 3000 && dones_a == d0; i++) @(negedge clk);
      check(tag, dones_a - d0, 1);
   endtask

   task automatic wait_sends_a(input int target, input string tag);
      for (int i = 0; i < 3000 && sends_a < target; i++) @(negedge clk);
      check(tag, sends_a, target);
   endtask

   initial begin
      int s0, d0, e0, lat;

      // Reset values while held in reset.
      repeat (3) @(negedge clk);
      check("a_reset_outs", {22'd0, tx_data_a, tx_send_a, rbusy_a, rdone_a, drop_a, err_a}, 0);
      check("b_reset_outs", {22'd0, tx_data_b, tx_send_b, rbusy_b, rdone_b, drop_b, err_b}, 0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // Line with CR LF: 45 %RH, 23 degC.
      s0 = sends_a;
      push_a(45, 23);
      pulse_a(45, 23);
      check("a_busy_after_accept", {31'd0, rbusy_a}, 1);
      lat = 1;
      while (!tx_send_a && lat < 40) begin @(negedge clk); lat++; end
      check("a_first_send_latency_ok", {31'd0, lat <= 24}, 1);
      wait_done_a("a_done_line1");
      check("a_sends_line1", sends_a - s0, 13);
      check("a_queue_empty_line1", q_a.size(), 0);
      check("a_busy_low_after_line1", {31'd0, rbusy_a}, 0);

      // Line without terminator: 255 %RH, 0 degC.
      for (int k = 0; k < 11; k++) q_b.push_back(line_byte(k, 255, 0));
      humid = 8'd255; temp = 8'd0; sv_b = 1'b1;
      @(negedge clk);
      sv_b = 1'b0;
      d0 = dones_b;
      for (int i = 0; i < 2000 && dones_b == d0; i++) @(negedge clk);
      check("b_done", dones_b - d0, 1);
      check("b_sends", sends_b, 11);
      check("b_queue_empty", q_b.size(), 0);

      // Sample during byte 5 is dropped; a sample one cycle after done is taken.
      s0 = sends_a; d0 = drops_a;
      push_a(10, 99);
      pulse_a(10, 99);
      wait_sends_a(s0 + 6, "a_reach_byte5");
      pulse_a(77, 88);
      repeat (3) @(negedge clk);
      check("a_dropped_once", drops_a - d0, 1);
      check("a_busy_during_drop", {31'd0, rbusy_a}, 1);
      for (int i = 0; i < 3000 && !rdone_a; i++) @(negedge clk);
      check("a_done_seen_line2", {31'd0, rdone_a}, 1);
      check("a_sends_line2", sends_a - s0, 13);
      push_a(200, 5);
      @(negedge clk);
      pulse_a(200, 5);
      check("a_accept_after_done", {31'd0, rbusy_a}, 1);
      wait_done_a("a_done_line3");
      check("a_no_drop_after_done", drops_a - d0, 1);
      check("a_queue_empty_line3", q_a.size(), 0);

      // uart never acknowledges: one 'H', then tx_err after the timeout.
      stuck_a = 1'b1;
      s0 = sends_a; e0 = errs_a;
      q_a.push_back(8'h48);
      pulse_a(1, 2);
      for (int i = 0; i < 100 && !tx_send_a; i++) @(negedge clk);
      lat = 0;
      while (!err_a && lat < 100) begin @(negedge clk); lat++; end
      check("a_err_delay_ok", {31'd0, (lat >= 15) && (lat <= 17)}, 1);
      check("a_busy_low_on_err", {31'd0, rbusy_a}, 0);
      repeat (50) @(negedge clk);
      check("a_err_once", errs_a - e0, 1);
      check("a_no_resend_after_err", sends_a - s0, 1);
      stuck_a = 1'b0;

      // uart busy before the report starts: no send until it clears.
      force_busy_a = 1'b1;
      s0 = sends_a;
      push_a(7, 8);
      pulse_a(7, 8);
      repeat (60) @(negedge clk);
      check("a_held_no_send", sends_a - s0, 0);
      force_busy_a = 1'b0;
      wait_done_a("a_done_held");
      check("a_sends_held", sends_a - s0, 13);

      // Reset during byte 7, then a clean line from 'H'.
      s0 = sends_a;
      push_a(12, 34);
      pulse_a(12, 34);
      wait_sends_a(s0 + 8, "a_reach_byte7");
      repeat (20) @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("a_async_reset_outs", {22'd0, tx_data_a, tx_send_a, rbusy_a, rdone_a, drop_a, err_a}, 0);
      q_a.delete();
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      s0 = sends_a;
      push_a(98, 76);
      pulse_a(98, 76);
      wait_done_a("a_done_after_reset");
      check("a_sends_after_reset", sends_a - s0, 13);
      check("a_queue_empty_end", q_a.size(), 0);
      check("b_no_err", errs_b, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
